// File: rtl/mips32_mmio_pkg.sv
// Shared definitions for the data-memory responder: MMIO register map,
// error-status bit positions and the address-decode result type.
package mips32_mmio_pkg;

  // MMIO registers are selected by word index within the 32-byte page
  localparam logic [2:0] REG_CYCLE       = 3'd0;  // byte offset 0x00
  localparam logic [2:0] REG_STORE_COUNT = 3'd1;  // byte offset 0x04
  localparam logic [2:0] REG_LED         = 3'd2;  // byte offset 0x08
  localparam logic [2:0] REG_ERR_STATUS  = 3'd3;  // byte offset 0x0C
  localparam logic [2:0] REG_ERR_ADDR    = 3'd4;  // byte offset 0x10

  localparam int ERR_MISALIGN    = 0;
  localparam int ERR_RANGE       = 1;
  localparam int ERR_RW_CONFLICT = 2;
  localparam int ERR_BITS        = 3;

  typedef enum logic [1:0] {
    DEC_RAM          = 2'd0,
    DEC_MMIO         = 2'd1,
    DEC_RANGE_ERR    = 2'd2,
    DEC_MISALIGN_ERR = 2'd3
  } decode_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// Word-organised data RAM: synchronous write, asynchronous read, no reset,
// so the core sees zero-wait-state loads.
module dmem_ram_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clock,
  input  logic          write_enable,
  input  logic [AW-1:0] word_addr,
  input  logic [31:0]   write_data,
  output logic [31:0]   read_data
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // store port: commits on the rising edge after the strobe
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem_r[word_addr] <= write_data;
    end
  end

  assign read_data = mem_r[word_addr];

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus a 32-byte MMIO page holding a cycle
// counter, store counter, LED register and sticky error capture.
module dmem_mmio_responder
  import mips32_mmio_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          LED_WIDTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 read_enable,
  input  logic                 write_enable,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic [31:0]          mem_out,
  output logic [LED_WIDTH-1:0] led,
  output logic                 err_irq
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(4 * DEPTH_WORDS);

  decode_e              dec_s;
  logic [2:0]           reg_sel_s;
  logic                 ram_we_s;
  logic                 mmio_we_s;
  logic                 read_ok_s;
  logic [31:0]          ram_rdata_s;
  logic [31:0]          mmio_rdata_s;
  logic [ERR_BITS-1:0]  err_set_s;
  logic [ERR_BITS-1:0]  err_clr_s;
  logic [ERR_BITS-1:0]  err_next_s;

  logic [31:0]          cycle_r;
  logic [31:0]          store_count_r;
  logic [31:0]          err_addr_r;
  logic [LED_WIDTH-1:0] led_r;
  logic [ERR_BITS-1:0]  err_status_r;

  // address decode; misalignment outranks every hit type
  always_comb begin
    if (address[1:0] != 2'b00) begin
      dec_s = DEC_MISALIGN_ERR;
    end else if ({1'b0, address} < RAM_BYTES) begin
      dec_s = DEC_RAM;
    end else if (address[31:5] == MMIO_BASE[31:5]) begin
      dec_s = DEC_MMIO;
    end else begin
      dec_s = DEC_RANGE_ERR;
    end
  end

  assign reg_sel_s = address[4:2];
  assign read_ok_s = read_enable & ~write_enable;
  // writes are dropped during reset so RAM cannot change under it
  assign ram_we_s  = write_enable & (dec_s == DEC_RAM) & ~reset;
  assign mmio_we_s = write_enable & (dec_s == DEC_MMIO);

  dmem_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clock        (clock),
    .write_enable (ram_we_s),
    .word_addr    (address[AW+1:2]),
    .write_data   (write_data),
    .read_data    (ram_rdata_s)
  );

  // error set/clear; a set lands on top of a same-cycle W1C clear
  always_comb begin
    err_set_s                  = {ERR_BITS{1'b0}};
    err_set_s[ERR_MISALIGN]    = (read_enable | write_enable) & (dec_s == DEC_MISALIGN_ERR);
    err_set_s[ERR_RANGE]       = (read_enable | write_enable) & (dec_s == DEC_RANGE_ERR);
    err_set_s[ERR_RW_CONFLICT] = read_enable & write_enable;
    if (mmio_we_s && (reg_sel_s == REG_ERR_STATUS)) begin
      err_clr_s = write_data[ERR_BITS-1:0];
    end else begin
      err_clr_s = {ERR_BITS{1'b0}};
    end
    err_next_s = (err_status_r & ~err_clr_s) | err_set_s;
  end

  // MMIO read mux; reserved slots read as zero
  always_comb begin
    case (reg_sel_s)
      REG_CYCLE:       mmio_rdata_s = cycle_r;
      REG_STORE_COUNT: mmio_rdata_s = store_count_r;
      REG_LED:         mmio_rdata_s = 32'(led_r);
      REG_ERR_STATUS:  mmio_rdata_s = 32'(err_status_r);
      REG_ERR_ADDR:    mmio_rdata_s = err_addr_r;
      default:         mmio_rdata_s = 32'd0;
    endcase
  end

  // same-cycle load data back to the core
  always_comb begin
    if (read_ok_s && (dec_s == DEC_RAM)) begin
      mem_out = ram_rdata_s;
    end else if (read_ok_s && (dec_s == DEC_MMIO)) begin
      mem_out = mmio_rdata_s;
    end else begin
      mem_out = 32'd0;
    end
  end

  // MMIO register state
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_r       <= 32'd0;
      store_count_r <= 32'd0;
      led_r         <= {LED_WIDTH{1'b0}};
      err_status_r  <= {ERR_BITS{1'b0}};
      err_addr_r    <= 32'd0;
    end else begin
      cycle_r      <= cycle_r + 32'd1;
      err_status_r <= err_next_s;
      if (ram_we_s) begin
        store_count_r <= sat_inc(store_count_r);
      end
      if (mmio_we_s && (reg_sel_s == REG_LED)) begin
        led_r <= write_data[LED_WIDTH-1:0];
      end
      if ((err_status_r == {ERR_BITS{1'b0}}) && (err_set_s != {ERR_BITS{1'b0}})) begin
        err_addr_r <= address;
      end
    end
  end

  assign led     = led_r;
  assign err_irq = |err_status_r;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: directed scenarios plus random
// traffic, checked against a behavioural model of the memory map.
module tb_dmem_mmio_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] mem_out;
  logic [7:0]  led;
  logic        err_irq;

  dmem_mmio_responder #(
    .DEPTH_WORDS (256),
    .MMIO_BASE   (32'hFFFF_0000),
    .LED_WIDTH   (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .address      (address),
    .write_data   (write_data),
    .mem_out      (mem_out),
    .led          (led),
    .err_irq      (err_irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] out;
    logic [7:0]  led;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference state
  logic [31:0] ram_m [256];
  logic [31:0] cycle_m = 32'd0;
  logic [31:0] sc_m    = 32'd0;
  logic [7:0]  led_m   = 8'd0;
  logic [2:0]  es_m    = 3'd0;
  logic [31:0] ea_m    = 32'd0;

  // 0 RAM, 1 MMIO, 2 out of range, 3 misaligned
  function automatic int kind_of(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 3;
    if (a < 32'd1024) return 0;
    if (a >= MB && (a - MB) < 32'd32) return 1;
    return 2;
  endfunction

  function logic [31:0] exp_read(input logic r, input logic w, input logic [31:0] a);
    int k;
    k = kind_of(a);
    if (!(r && !w)) return 32'd0;
    if (k == 0) return ram_m[a[9:2]];
    if (k != 1) return 32'd0;
    case (a - MB)
      32'd0:   return cycle_m;
      32'd4:   return sc_m;
      32'd8:   return {24'd0, led_m};
      32'd12:  return {29'd0, es_m};
      32'd16:  return ea_m;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_update(input logic rst, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
    int         k;
    logic [2:0] set_b;
    logic [2:0] clr_b;
    if (rst) begin
      cycle_m = 32'd0; sc_m = 32'd0; led_m = 8'd0; es_m = 3'd0; ea_m = 32'd0;
      return;
    end
    k = kind_of(a);
    set_b = 3'b000;
    clr_b = 3'b000;
    if ((r || w) && k == 3) set_b[0] = 1'b1;
    if ((r || w) && k == 2) set_b[1] = 1'b1;
    if (r && w) set_b[2] = 1'b1;
    if (w && k == 0) begin
      ram_m[a[9:2]] = d;
      if (sc_m != 32'hFFFF_FFFF) sc_m = sc_m + 32'd1;
    end
    if (w && k == 1) begin
      if ((a - MB) == 32'd8)  led_m = d[7:0];
      if ((a - MB) == 32'd12) clr_b = d[2:0];
    end
    if (es_m == 3'd0 && set_b != 3'd0) ea_m = a;
    es_m    = (es_m & ~clr_b) | set_b;
    cycle_m = cycle_m + 32'd1;
  endtask

  // drive one cycle (called #1 after a rising edge), queue its expectation
  task automatic step(input logic rst, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    reset = rst; read_enable = r; write_enable = w; address = a; write_data = d;
    e.addr = a;
    e.out  = exp_read(r, w, a);
    e.led  = led_m;
    e.irq  = (es_m != 3'd0);
    sb.push_back(e);
    model_update(rst, r, w, a, d);
    @(posedge clock);
    #1;
  endtask

  // monitor: compare the presented outputs mid-cycle
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp = n_cmp + 1;
      if (mem_out !== e.out) begin
        n_bad = n_bad + 1;
        $display("FAIL mem_out addr=%h: got %h want %h", e.addr, mem_out, e.out);
      end
      n_cmp = n_cmp + 1;
      if (led !== e.led) begin
        n_bad = n_bad + 1;
        $display("FAIL led addr=%h: got %h want %h", e.addr, led, e.led);
      end
      n_cmp = n_cmp + 1;
      if (err_irq !== e.irq) begin
        n_bad = n_bad + 1;
        $display("FAIL err_irq addr=%h: got %b want %b", e.addr, err_irq, e.irq);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          sel;
    reset = 1'b1; read_enable = 1'b0; write_enable = 1'b0;
    address = 32'd0; write_data = 32'd0;
    repeat (3) @(posedge clock);
    #1;

    // store then load, store counter, error flag clear
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
    step(1'b0, 1'b1, 1'b0, MB + 32'h04, 32'd0);

    // fill RAM so every later load has a known value
    for (int i = 0; i < 256; i++) step(1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom);

    // cycle counter over an idle gap
    step(1'b0, 1'b1, 1'b0, MB, 32'd0);
    repeat (7) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b0, MB, 32'd0);

    // LED write, readback, ignored write to CYCLE
    step(1'b0, 1'b0, 1'b1, MB + 32'h08, 32'h1A5);
    step(1'b0, 1'b1, 1'b0, MB + 32'h08, 32'd0);
    step(1'b0, 1'b0, 1'b1, MB, 32'h1234_5678);
    step(1'b0, 1'b1, 1'b0, MB, 32'd0);
    step(1'b0, 1'b1, 1'b0, MB + 32'h18, 32'd0);

    // misaligned store, range load, W1C
    step(1'b0, 1'b0, 1'b1, 32'h42, 32'h1111_2222);
    step(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
    step(1'b0, 1'b1, 1'b0, MB + 32'h0C, 32'd0);
    step(1'b0, 1'b1, 1'b0, MB + 32'h10, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h2000, 32'd0);
    step(1'b0, 1'b1, 1'b0, MB + 32'h0C, 32'd0);
    step(1'b0, 1'b1, 1'b0, MB + 32'h10, 32'd0);
    step(1'b0, 1'b0, 1'b1, MB + 32'h0C, 32'h3);
    step(1'b0, 1'b1, 1'b0, MB + 32'h0C, 32'd0);

    // read/write conflict; conflict set beats a same-cycle W1C
    step(1'b0, 1'b1, 1'b1, 32'h10, 32'h55);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    step(1'b0, 1'b1, 1'b0, MB + 32'h0C, 32'd0);
    step(1'b0, 1'b1, 1'b1, MB + 32'h0C, 32'h4);
    step(1'b0, 1'b1, 1'b0, MB + 32'h0C, 32'd0);

    // reset with a pending LED store
    step(1'b1, 1'b0, 1'b1, MB + 32'h08, 32'h77);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, MB + 32'(i * 4), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, 255) * 4);
        5:             a = 32'($urandom_range(0, 1023));
        6, 7:          a = MB + 32'($urandom_range(0, 31));
        8:             a = 32'h400 + 32'($urandom_range(0, 4096) * 4);
        default:       a = $urandom;
      endcase
      step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, a,
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom);
    end

    reset = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder for the core's data-memory interface: it answers the core's read/write strobes, address, write data and read data.
- Replaces the plain data memory at top level with word RAM plus a small memory-mapped I/O page: cycle counter, store counter, LED register, and error status/address capture.
- Zero-wait-state: the single-cycle core has no stall input, so reads resolve within the cycle and writes commit on the next rising edge.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit RAM words; RAM covers byte addresses 0 to 4*DEPTH_WORDS-1.
- MMIO_BASE, 32'hFFFF_0000, base byte address of the 32-byte MMIO page.
- LED_WIDTH, 8, width of the LED output register.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- read_enable, input, 1, core read strobe.
- write_enable, input, 1, core write strobe.
- address, input, 32, byte address from the core.
- write_data, input, 32, store data from the core.
- mem_out, output, 32, read data to the core (combinational).
- led, output, LED_WIDTH, LED register contents.
- err_irq, output, 1, OR of the ERR_STATUS bits.

Behaviour:
- Reset (synchronous, active-high):
  - Clears CYCLE, STORE_COUNT, LED, ERR_STATUS and ERR_ADDR to 0.
  - RAM contents are not cleared.
  - led=0 and err_irq=0 on the cycle after reset is sampled high.
  - A write presented during a reset cycle is dropped.
- Decode (combinational, on address):
  - RAM hit: address < 4*DEPTH_WORDS.
  - MMIO hit: address[31:5] == MMIO_BASE[31:5].
  - Any other address is out-of-range.
  - Misaligned: address[1:0] != 0; this check takes precedence over the hit type.
- Read, when read_enable=1, write_enable=0 and the access is legal:
  - mem_out = RAM word at address[31:2], or the selected MMIO register, in the same cycle.
  - In all other cases mem_out = 0.
- Write, when write_enable=1 and the access is legal:
  - The target updates on the next rising edge.
  - A read of the same address in the following cycle returns the new value; there is no same-cycle bypass.
- MMIO map (offset, name, access):
  - 0x00 CYCLE, RO: free-running, +1 every cycle, wraps 0xFFFFFFFF->0.
  - 0x04 STORE_COUNT, RO: +1 per accepted RAM write; saturates at 0xFFFFFFFF.
  - 0x08 LED, RW: low LED_WIDTH bits written; reads zero-extended.
  - 0x0C ERR_STATUS, R/W1C:
    - bit0 MISALIGN, bit1 RANGE, bit2 RW_CONFLICT.
    - Writing 1 clears the corresponding bit.
  - 0x10 ERR_ADDR, RO: address of the first error since ERR_STATUS was last all-zero.
  - 0x14-0x1C: reserved; read 0, writes ignored, no error flagged.
  - Writes to RO registers are ignored silently.
- Error handling:
  - Any strobed access that is misaligned or out-of-range:
    - Sets the corresponding sticky bit.
    - Write is dropped; mem_out = 0.
  - read_enable and write_enable both high:
    - Sets RW_CONFLICT.
    - The write proceeds if legal; mem_out = 0.
  - ERR_ADDR captures the address only when ERR_STATUS is 0 before the edge.
  - If a set and a W1C clear of the same bit fall in the same cycle, the set wins.
  - err_irq is registered-state derived: |ERR_STATUS, with no extra latency beyond the register.
- Idle (no strobes): no state change other than CYCLE; mem_out = 0.

Decomposition:
- Package mips32_mmio_pkg:
  - MMIO register offsets.
  - ERR_STATUS bit indices.
  - Decode-result enum: RAM, MMIO, RANGE_ERR, MISALIGN_ERR.
- Sub-module dmem_ram_array: DEPTH_WORDS x 32, synchronous write, asynchronous read, no reset.
- The parent holds decode, the MMIO registers and the error logic.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x40 and read 0x40 the next cycle -> mem_out=0xDEADBEEF; STORE_COUNT reads 1; err_irq=0.
- Read CYCLE in two cycles N apart -> difference = N. Force CYCLE to 0xFFFFFFFF -> next cycle it reads 0.
- Write 0x1A5 to MMIO_BASE+0x08 -> led=0xA5; readback 0x000000A5. Write to MMIO_BASE+0x00 -> CYCLE unaffected.
- Write to 0x42 (misaligned) -> RAM unchanged; ERR_STATUS=0x1; ERR_ADDR=0x42; err_irq=1. Then read 0x2000 (range, DEPTH 256) -> ERR_STATUS=0x3 and ERR_ADDR stays 0x42. Write 0x3 to ERR_STATUS -> 0, err_irq=0.
- read_enable=write_enable=1 at 0x10 with data 0x55 -> mem_out=0; RAM[4]=0x55 after the edge; RW_CONFLICT set. Same cycle as a W1C of bit2 -> bit2 remains 1.
- Assert reset mid-stream while a write of 0x77 to LED is strobed -> led=0, all MMIO registers 0; RAM word written earlier retains its value.
